// File: rtl/mmio_io_responder_if.sv
// mmio_io_responder_if: core-side IO load/store bus between memory decode and the IO responder
interface mmio_io_responder_if;
  logic [31:0] io_adr;
  logic [31:0] io_wdata;
  logic        iowea;
  logic        io_re;
  logic [31:0] io_rdata;
  modport master (output io_adr, io_wdata, iowea, io_re, input io_rdata);
  modport slave (input io_adr, io_wdata, iowea, io_re, output io_rdata);
endinterface

// File: rtl/mmio_io_responder.sv
// mmio_io_responder: IO-space register block with UART TX holding register, RX FIFO and cycle/instret counters
module mmio_io_responder #(
  parameter int RX_FIFO_DEPTH = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mmio_io_responder_if.slave    bus,
  input  logic                  inst_retired,
  output logic [7:0]            tx_data_out,
  output logic                  tx_data_out_valid,
  input  logic                  tx_data_out_ready,
  input  logic [7:0]            rx_data_in,
  input  logic                  rx_data_in_valid,
  output logic                  rx_data_in_ready
);
  localparam int PW = $clog2(RX_FIFO_DEPTH);
  localparam logic [PW:0] DEPTH = (PW + 1)'(RX_FIFO_DEPTH);
  logic [7:0]           fifo [RX_FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [PW:0]          count;
  logic [CNT_WIDTH-1:0] cyc, ins;
  logic [3:0]           off;
  logic                 rx_full, rx_nonempty, pop, push, tx_wr, clr;
  logic [31:0]          rd_val;
  // Address decode, handshake qualifiers and the load data mux for the M stage
  always_comb begin
    off = bus.io_adr[5:2];
    rx_full = count == DEPTH;
    rx_nonempty = count != '0;
    rx_data_in_ready = !rx_full;
    pop = bus.io_re && off == 4'd1 && rx_nonempty;
    // A pop frees the slot at the same edge, so a full FIFO can still take a byte alongside a read
    push = rx_data_in_valid && (!rx_full || pop);
    tx_wr = bus.iowea && off == 4'd2 && (!tx_data_out_valid || tx_data_out_ready);
    clr = bus.iowea && off == 4'd6;
    rd_val = off == 4'd0 ? {30'b0, rx_nonempty, !tx_data_out_valid} :
             off == 4'd1 ? (rx_nonempty ? {24'b0, fifo[rd_ptr]} : 32'b0) :
             off == 4'd4 ? 32'(cyc) :
             off == 4'd5 ? 32'(ins) : 32'b0;
  end
  // RX FIFO storage; contents need no reset since reads are gated by the count
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= rx_data_in;
  end
  // Registered load data, TX holding register, FIFO pointers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.io_rdata <= '0;
      tx_data_out <= '0;
      tx_data_out_valid <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      cyc <= '0;
      ins <= '0;
    end else begin
      if (bus.io_re) bus.io_rdata <= rd_val;
      if (tx_wr) begin
        tx_data_out <= bus.io_wdata[7:0];
        tx_data_out_valid <= 1'b1;
      end else if (tx_data_out_ready) tx_data_out_valid <= 1'b0;
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
      cyc <= clr ? '0 : cyc + CNT_WIDTH'(1);
      ins <= clr ? '0 : ins + CNT_WIDTH'(inst_retired);
    end
  end
endmodule

// File: tb/tb_mmio_io_responder.sv
// tb_mmio_io_responder: directed and randomized checks against a queue-based reference model
module tb_mmio_io_responder;
  localparam int DEPTH = 8;
  localparam int CW = 8;
  localparam int unsigned CMASK = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inst_retired = 1'b0;
  logic [7:0] tx_data_out;
  logic tx_data_out_valid;
  logic tx_data_out_ready = 1'b0;
  logic [7:0] rx_data_in = 8'h0;
  logic rx_data_in_valid = 1'b0;
  logic rx_data_in_ready;
  int vectors = 0;
  int errs = 0;
  logic [7:0] q[$];
  logic m_tx_v = 1'b0;
  logic [7:0] m_tx_d = 8'h0;
  int unsigned m_cyc = 0;
  int unsigned m_ins = 0;
  logic [31:0] m_rdata = 32'h0;
  mmio_io_responder_if bus();
  mmio_io_responder #(.RX_FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .inst_retired(inst_retired),
    .tx_data_out(tx_data_out), .tx_data_out_valid(tx_data_out_valid),
    .tx_data_out_ready(tx_data_out_ready), .rx_data_in(rx_data_in),
    .rx_data_in_valid(rx_data_in_valid), .rx_data_in_ready(rx_data_in_ready)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int off;
    logic [31:0] val;
    logic pop, push;
    off = int'(bus.io_adr[5:2]);
    if (rst) begin
      q.delete();
      m_tx_v = 1'b0;
      m_tx_d = 8'h0;
      m_cyc = 0;
      m_ins = 0;
      m_rdata = 32'h0;
    end else begin
      case (off)
        0: val = {30'b0, q.size() > 0, !m_tx_v};
        1: val = q.size() > 0 ? {24'b0, q[0]} : 32'h0;
        4: val = m_cyc;
        5: val = m_ins;
        default: val = 32'h0;
      endcase
      if (bus.io_re) m_rdata = val;
      pop = bus.io_re && off == 1 && q.size() > 0;
      push = rx_data_in_valid && (q.size() < DEPTH || pop);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(rx_data_in);
      if (bus.iowea && off == 2 && (!m_tx_v || tx_data_out_ready)) begin
        m_tx_v = 1'b1;
        m_tx_d = bus.io_wdata[7:0];
      end else if (tx_data_out_ready) m_tx_v = 1'b0;
      if (bus.iowea && off == 6) begin
        m_cyc = 0;
        m_ins = 0;
      end else begin
        m_cyc = (m_cyc + 1) & CMASK;
        m_ins = (m_ins + (inst_retired ? 1 : 0)) & CMASK;
      end
    end
    @(posedge clk);
    #1;
    chk("rdata", bus.io_rdata, m_rdata);
    chk("tx_valid", 32'(tx_data_out_valid), 32'(m_tx_v));
    chk("tx_data", 32'(tx_data_out), 32'(m_tx_d));
    chk("rx_ready", 32'(rx_data_in_ready), 32'(q.size() < DEPTH));
  endtask

  task automatic io(input logic re, input logic we, input logic [31:0] adr, input logic [31:0] wd);
    bus.io_re = re;
    bus.iowea = we;
    bus.io_adr = adr;
    bus.io_wdata = wd;
    cycle();
    bus.io_re = 1'b0;
    bus.iowea = 1'b0;
  endtask

  initial begin
    bus.io_re = 1'b0;
    bus.iowea = 1'b0;
    bus.io_adr = 32'h0;
    bus.io_wdata = 32'h0;
    cycle();
    cycle();
    rst = 1'b0;
    io(1, 0, 32'h8000_0000, 0);
    chk("t1_status", bus.io_rdata, 32'h1);
    chk("t1_rx_ready", 32'(rx_data_in_ready), 32'h1);
    io(0, 1, 32'h8000_0008, 32'h41);
    repeat (3) cycle();
    io(0, 1, 32'h8000_0008, 32'h42);
    io(1, 0, 32'h8000_0000, 0);
    chk("t2_held", 32'(tx_data_out), 32'h41);
    chk("t2_status", bus.io_rdata, 32'h0);
    tx_data_out_ready = 1'b1;
    cycle();
    tx_data_out_ready = 1'b0;
    chk("t2_sent", 32'(tx_data_out_valid), 32'h0);
    io(1, 0, 32'h8000_0000, 0);
    chk("t2_status2", bus.io_rdata, 32'h1);
    rx_data_in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data_in = 8'h10 + 8'(i);
      cycle();
    end
    chk("t3_full", 32'(rx_data_in_ready), 32'h0);
    rx_data_in = 8'h18;
    io(1, 0, 32'h8000_0004, 0);
    rx_data_in_valid = 1'b0;
    chk("t3_head", bus.io_rdata, 32'h10);
    chk("t3_still_full", 32'(rx_data_in_ready), 32'h0);
    for (int i = 0; i < 8; i++) begin
      io(1, 0, 32'h8000_0004, 0);
      chk("t3_drain", bus.io_rdata, 32'h11 + 32'(i));
    end
    io(1, 0, 32'h8000_0004, 0);
    chk("t3_empty_rd", bus.io_rdata, 32'h0);
    io(1, 0, 32'h8000_0000, 0);
    chk("t3_status", bus.io_rdata, 32'h1);
    io(0, 1, 32'h8000_0018, 0);
    for (int i = 0; i < 300 && m_cyc != CMASK; i++) cycle();
    io(1, 0, 32'h8000_0010, 0);
    chk("t4_allones", bus.io_rdata, 32'(CMASK));
    io(1, 0, 32'h8000_0010, 0);
    chk("t4_wrap", bus.io_rdata, 32'h0);
    inst_retired = 1'b1;
    repeat (3) cycle();
    inst_retired = 1'b0;
    io(1, 0, 32'h8000_0014, 0);
    chk("t5_count", bus.io_rdata, 32'h3);
    inst_retired = 1'b1;
    io(0, 1, 32'h8000_0018, 0);
    inst_retired = 1'b0;
    io(1, 0, 32'h8000_0014, 0);
    chk("t5_clear", bus.io_rdata, 32'h0);
    io(0, 1, 32'h8000_0008, 32'h55);
    rx_data_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data_in = 8'($urandom);
      cycle();
    end
    rx_data_in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_tx_valid", 32'(tx_data_out_valid), 32'h0);
    chk("t6_tx_data", 32'(tx_data_out), 32'h0);
    chk("t6_rx_ready", 32'(rx_data_in_ready), 32'h1);
    io(1, 0, 32'h8000_0000, 0);
    chk("t6_status", bus.io_rdata, 32'h1);
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(0, 79) == 0;
      rx_data_in_valid = 1'($urandom);
      rx_data_in = 8'($urandom);
      tx_data_out_ready = $urandom_range(0, 3) == 0;
      inst_retired = 1'($urandom);
      io(1'($urandom), $urandom_range(0, 2) == 0,
         ($urandom & 32'hFFFF_FFC3) | {26'b0, 4'($urandom_range(0, 7)), 2'b0}, $urandom);
    end
    rst = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
